// File: rtl/add_sub_acc_if.sv
// rtl/add_sub_acc_if.sv - operand stream and result bus for the add/sub accumulator
`timescale 1ns/1ps
interface add_sub_acc_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             i_start;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             i_s;
    logic [WIDTH-1:0] o_acc;
    logic             o_cout;
    logic             o_ovf;
    logic             o_zero;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_cnt;

    modport master (
        output i_start, i_valid, i_data, i_s,
        input  o_ready, o_acc, o_cout, o_ovf, o_zero, o_busy, o_done, o_cnt
    );

    modport slave (
        input  i_start, i_valid, i_data, i_s,
        output o_ready, o_acc, o_cout, o_ovf, o_zero, o_busy, o_done, o_cnt
    );
endinterface

// File: rtl/add_sub_acc.sv
// rtl/add_sub_acc.sv - sequenced add/subtract accumulator with carry, sticky overflow and zero flags
`timescale 1ns/1ps
module add_sub_acc #(
    parameter int WIDTH = 4,
    parameter int N_OPS = 4,
    parameter int CNT_W = $clog2(N_OPS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    add_sub_acc_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic             accept;
    logic             last_beat;
    logic             start_seq;
    logic             ovf_step;

    // Subtract is acc + ~data + 1, so cout=1 means no borrow
    always_comb begin
        opnd      = bus.i_s ? ~bus.i_data : bus.i_data;
        sum       = {1'b0, acc_q} + {1'b0, opnd} + {{WIDTH{1'b0}}, bus.i_s};
        accept    = (state_q == ST_RUN) && bus.i_valid;
        last_beat = accept && (cnt_q == CNT_W'(N_OPS - 1));
        start_seq = (state_q == ST_IDLE) && bus.i_start;
        ovf_step  = (acc_q[MSB] == opnd[MSB]) && (sum[MSB] != acc_q[MSB]);
    end

    // State register; reset aborts any sequence without a done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start only honoured in IDLE, DONE always lasts one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.i_start) state_d = ST_RUN;
            ST_RUN:  if (last_beat)   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers: cleared on start, updated per accepted beat, otherwise held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (start_seq) begin
            acc_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            acc_q  <= sum[WIDTH-1:0];
            cout_q <= sum[WIDTH];
            ovf_q  <= ovf_q | ovf_step;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.o_acc   = acc_q;
    assign bus.o_cout  = cout_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_cnt   = cnt_q;
    assign bus.o_zero  = (acc_q == '0);
    assign bus.o_ready = (state_q == ST_RUN);
    assign bus.o_busy  = (state_q == ST_RUN);
    assign bus.o_done  = (state_q == ST_DONE);

endmodule

// File: doc/add_sub_acc.md
Name: add_sub_acc

Overview:
- Sequential accumulator stage directly downstream of the 4-bit add/sub datapath.
- Accepts a stream of operands over a valid/ready handshake.
- Each operand carries its own add/subtract select; the block adds it to, or subtracts it from, a registered running result.
- After a programmed number of operations it reports the final result with carry, sticky signed-overflow and zero flags, then returns to idle.

Parameters:
- WIDTH, 4, operand and accumulator width in bits.
- N_OPS, 4, operations accepted per sequence (>=1).
- CNT_W, $clog2(N_OPS+1), derived width of the operation counter. Do not override.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  begin a new sequence. Sampled in IDLE only.
- i_valid  input  1  operand valid.
- o_ready  output  1  block accepts an operand this cycle.
- i_data  input  WIDTH  operand.
- i_s  input  1  per-operand select: 0 = add, 1 = subtract.
- o_acc  output  WIDTH  registered running result.
- o_cout  output  1  carry-out of the last accepted operation. For subtract, 1 = no borrow.
- o_ovf  output  1  sticky signed overflow for the current sequence.
- o_zero  output  1  o_acc == 0.
- o_busy  output  1  sequence in progress (RUN state).
- o_done  output  1  one-cycle pulse when the sequence completes.
- o_cnt  output  CNT_W  operations accepted in the current sequence.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - o_acc=0, o_cout=0, o_ovf=0, o_cnt=0, o_busy=0, o_done=0, o_ready=0.
  - o_zero=1, since it is derived from o_acc.
  - Reset mid-sequence aborts immediately. No done pulse is produced.
- Outputs:
  - All outputs are registered or derived from registered state only. No combinational path from input ports.
  - o_ready = (state==RUN). o_busy = (state==RUN).
- FSM:
  - IDLE: if i_start=1, next cycle is RUN with o_acc=0, o_cout=0, o_ovf=0, o_cnt=0. Otherwise hold all registers.
  - RUN: a beat is accepted when i_valid & o_ready. On acceptance:
    - o_acc <= low WIDTH bits of (acc + opnd + i_s), where opnd = i_s ? ~i_data : i_data.
    - o_cout <= bit WIDTH of that (WIDTH+1)-bit sum.
    - o_ovf <= o_ovf | (acc[MSB]==opnd[MSB] && result[MSB]!=acc[MSB]).
    - o_cnt <= o_cnt+1.
  - RUN, no acceptance: all registers hold.
  - RUN -> DONE on the accepted beat where o_cnt == N_OPS-1.
  - DONE: lasts exactly one cycle with o_done=1, o_ready=0, o_busy=0, and results held. Then goes to IDLE.
- Result hold: results (o_acc, o_cout, o_ovf, o_cnt=N_OPS) stay valid in IDLE until the next accepted i_start.
- Input rules:
  - i_start is ignored in RUN and DONE. i_start in the DONE cycle is not queued.
  - i_valid outside RUN is ignored. The data is not consumed.
- Latency: the accepted operand affects o_acc on the first rising edge after acceptance. Throughput is 1 operand per cycle.
- Wrap-around: the accumulator wraps modulo 2^WIDTH. It never saturates.
- Counter: o_cnt never exceeds N_OPS.

Test Plan:
1. Assert i_rst_n=0 with random inputs -> o_acc=0, o_zero=1, o_ready=0, o_busy=0, o_done=0, o_cnt=0. Release reset, hold i_start=0 for 5 cycles -> all unchanged.
2. Pulse i_start, then feed add beats 3, 5, 7, 1 back-to-back with i_valid=1 -> o_acc sequence 3, 8, F, 0.
   - o_ovf goes to 1 after 3+5 and stays 1.
   - o_cout is 1 only after F+1.
   - o_cnt 1, 2, 3, 4.
   - o_done pulses one cycle after the 4th beat, with o_zero=1.
3. Pulse i_start, then subtract beats 1, 1 followed by add beats 3, 4:
   - 0-1 -> o_acc=F, o_cout=0.
   - F-1 -> o_acc=E, o_cout=1.
   - E+3 -> o_acc=1, o_cout=1.
   - 1+4 -> o_acc=5, o_cout=0.
   - o_ovf=0 throughout. o_done pulses.
4. In RUN, drop i_valid for 3 cycles between beats while i_data toggles -> o_acc and o_cnt hold, o_ready stays 1. Resume -> sequence completes with the correct sum.
5. Assert i_start during RUN after 2 beats -> ignored, o_cnt continues to 4. Then drive async reset low mid-clock after 2 beats of the next sequence -> outputs clear immediately, no o_done, state IDLE.
6. Set N_OPS=1 and drive i_start with i_valid held high and i_data=7 from IDLE -> no acceptance in IDLE. One accepted beat in RUN gives o_acc=7, o_done the next cycle, then IDLE with o_cnt=1.
